cache_writeback_buffer: RTL and testbench
=========================================

CACHE_WRITEBACK_BUFFER -- requirements
Module: cache_writeback_buffer

Interface
REQ-001 The module SHALL have parameter NUMWAYS, default 4, giving the cache associativity (power of 2, at least 2).
REQ-002 The module SHALL have parameter LINELEN, default 512, giving the cache line width in bits.
REQ-003 The module SHALL have parameter WORDLEN, default 64, giving the bus beat width in bits; LINELEN is a multiple of WORDLEN.
REQ-004 The module SHALL have parameter PA_BITS, default 32, giving the physical address width.
REQ-005 The module SHALL have parameter DEPTH, default 2, giving the number of line entries (power of 2).
REQ-006 Port clk  input  1  is the single clock; all state SHALL be updated on its rising edge.
REQ-007 Port reset  input  1  SHALL be an asynchronous, active-high reset.
REQ-008 Port EvictReq  input  1  requests that an evicted line be captured.
REQ-009 Port VictimWay  input  NUMWAYS  is the one-hot way being evicted, as produced by the LRU.
REQ-010 Port VictimDirty  input  1  indicates that the victim line is dirty.
REQ-011 Port EvictAdr  input  PA_BITS  is the line-aligned address of the victim.
REQ-012 Port EvictLine  input  LINELEN  is the victim line data.
REQ-013 Port EvictReady  output  1  indicates that an entry is free.
REQ-014 Port BusValid  output  1  indicates that a write beat is presented on the bus.
REQ-015 Ports BusAdr  output  PA_BITS, BusData  output  WORDLEN, BusLast  output  1, and DrainWay  output  log2(NUMWAYS) SHALL carry the current beat's address, data, last-beat flag, and encoded way.
REQ-016 Port BusReady  input  1  indicates that the bus accepts the current beat.
REQ-017 Port Busy  output  1  SHALL be high whenever any entry is occupied.

Function
REQ-018 A push SHALL occur only when EvictReq, EvictReady and VictimDirty are high and VictimWay is nonzero in the same cycle; in all other cycles the inputs SHALL be ignored.
REQ-019 A clean victim (VictimDirty=0) SHALL be dropped without creating an entry.
REQ-020 A pushed entry SHALL store EvictAdr, EvictLine, and the binary encoding of VictimWay.
REQ-021 EvictReady SHALL equal "not full", registered only; a pop in the same cycle SHALL NOT free the slot for a push in that cycle.
REQ-022 Storage SHALL be a circular FIFO with DEPTH entries; the write and read pointers SHALL wrap modulo DEPTH, and an occupancy count of 0..DEPTH SHALL distinguish full from empty.
REQ-023 The drain FSM SHALL have two states: IDLE and SEND.
REQ-024 In IDLE with the FIFO non-empty, the FSM SHALL move to SEND with beat=0; a push into an empty FIFO SHALL produce BusValid no earlier than the following cycle.
REQ-025 In SEND, BusValid SHALL be 1, and BusData SHALL equal bits [beat*WORDLEN +: WORDLEN] of the head entry's line.
REQ-026 In SEND, BusAdr SHALL equal head address + beat*(WORDLEN/8), computed modulo 2^PA_BITS.
REQ-027 BusLast SHALL be high when beat equals LINELEN/WORDLEN-1.
REQ-028 The beat counter SHALL advance only on BusValid&BusReady.
REQ-029 A BusReady&BusLast handshake SHALL pop the head entry; the FSM SHALL then go to IDLE if the FIFO becomes empty, and otherwise stay in SEND with beat=0.
REQ-030 While BusValid is high and BusReady is low, BusAdr, BusData, BusLast and DrainWay SHALL be held stable.
REQ-031 A simultaneous push and pop SHALL leave occupancy unchanged and SHALL preserve FIFO order.

Reset
REQ-032 Reset SHALL clear the pointers and count, place the FSM in IDLE with beat=0, and drive BusValid=0, BusLast=0, Busy=0 and EvictReady=1.
REQ-033 BusAdr, BusData and DrainWay SHALL be 0 while in IDLE.
REQ-034 Reset asserted mid-burst SHALL abandon the burst and discard all entries; line data storage need not be reset.

Configuration
REQ-035 With WBBUF_FORWARD_EN defined, the module SHALL add inputs LookupAdr (PA_BITS) and output LookupHit.
REQ-036 LookupHit SHALL be combinational and high when any occupied entry's line-aligned address equals the line-aligned LookupAdr, including the head entry mid-burst.
REQ-037 Without WBBUF_FORWARD_EN, neither port SHALL exist and no comparators SHALL be built.

Structure
REQ-038 A shared cache package SHALL hold the entry struct (address, line, way) and the constant BEATS = LINELEN/WORDLEN.
REQ-039 The FIFO storage and pointer logic SHALL be one sub-module, wbfifo; the drain FSM SHALL stay in the top module.

Verification
REQ-040 Scenario: push dirty line Adr=0x80001000, way 0b0100 (LINELEN=512, WORDLEN=64), BusReady=1 -> 8 beats at 0x80001000..0x80001038, BusLast on beat 7, DrainWay=2, then Busy=0.
REQ-041 Scenario: push a clean victim -> no BusValid, and Busy stays 0.
REQ-042 Scenario: two pushes with BusReady=0 -> EvictReady=0; a third push is ignored; releasing BusReady -> both lines drain in order with no idle cycle between them.
REQ-043 Scenario: BusReady toggling 1,0,1,0 -> each beat held stable until accepted, and the beat count is 8.
REQ-044 Scenario: reset asserted at beat 3 -> BusValid=0 immediately, EvictReady=1, and no further beats.
REQ-045 Scenario (with WBBUF_FORWARD_EN): LookupAdr=0x80001020 while 0x80001000 is queued -> LookupHit=1; after the pop -> LookupHit=0.

Source files
------------

// File: rtl/cache_writeback_buffer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cache_writeback_buffer_pkg
//  Brief    : Shared types and constants for the cache write-back buffer:
//             the queued entry layout, the drain FSM state encoding and the
//             beats-per-line constant for the default cache geometry.
//  Revision : 1.0  initial release
// ============================================================================
package cache_writeback_buffer_pkg;

    // Default cache geometry used by the buffer's parameter defaults.
    localparam int c_DEF_NUMWAYS = 4;
    localparam int c_DEF_LINELEN = 512;
    localparam int c_DEF_WORDLEN = 64;
    localparam int c_DEF_PA_BITS = 32;
    localparam int c_DEF_DEPTH   = 2;

    // Number of bus beats needed to move one line.
    localparam int BEATS = c_DEF_LINELEN / c_DEF_WORDLEN;

    // One queued victim: line-aligned address, line data and encoded way.
    typedef struct packed {
        logic [c_DEF_PA_BITS-1:0]         adr;
        logic [c_DEF_LINELEN-1:0]         line;
        logic [$clog2(c_DEF_NUMWAYS)-1:0] way;
    } wbEntry_t;

    // Drain state machine encoding.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } drainState_t;

endpackage : cache_writeback_buffer_pkg
`default_nettype wire

// File: rtl/cache_writeback_buffer_wbfifo.sv
`default_nettype none
// ============================================================================
//  Module   : wbfifo
//  Brief    : Circular FIFO of evicted lines for the write-back buffer.
//             Occupancy count 0..DEPTH separates full from empty. With
//             WBBUF_FORWARD_EN defined, a per-entry line-address comparator
//             reports whether a lookup address is still queued.
//  Revision : 1.0  initial release
// ============================================================================
module wbfifo
    import cache_writeback_buffer_pkg::*;
#(
    parameter int PA_BITS = 32,
    parameter int LINELEN = 512,
    parameter int WAYBITS = 2,
    parameter int DEPTH   = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic [PA_BITS-1:0] pushAdr,
    input  logic [LINELEN-1:0] pushLine,
    input  logic [WAYBITS-1:0] pushWay,
    input  logic               pop,
    output logic               full,
    output logic               empty,
    output logic               lastEntry,
    output logic [PA_BITS-1:0] headAdr,
    output logic [LINELEN-1:0] headLine,
    output logic [WAYBITS-1:0] headWay
`ifdef WBBUF_FORWARD_EN
    ,
    input  logic [PA_BITS-1:0] LookupAdr,
    output logic               LookupHit
`endif
);

    localparam int c_PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNTW = $clog2(DEPTH + 1);

    logic [c_PTRW-1:0]  r_wrPtr;
    logic [c_PTRW-1:0]  r_rdPtr;
    logic [c_CNTW-1:0]  r_count;

    logic [PA_BITS-1:0] r_adrMem  [DEPTH];
    logic [LINELEN-1:0] r_lineMem [DEPTH];
    logic [WAYBITS-1:0] r_wayMem  [DEPTH];

    // Pointers wrap at DEPTH; count tracks occupancy so push+pop nets to zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (push) begin
                r_wrPtr <= (r_wrPtr == c_PTRW'(DEPTH - 1)) ? '0 : r_wrPtr + 1'b1;
            end
            if (pop) begin
                r_rdPtr <= (r_rdPtr == c_PTRW'(DEPTH - 1)) ? '0 : r_rdPtr + 1'b1;
            end
            case ({push, pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage is data only, so it carries no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            r_adrMem[r_wrPtr]  <= pushAdr;
            r_lineMem[r_wrPtr] <= pushLine;
            r_wayMem[r_wrPtr]  <= pushWay;
        end
    end

    assign full      = (r_count == c_CNTW'(DEPTH));
    assign empty     = (r_count == '0);
    assign lastEntry = (r_count == c_CNTW'(1));
    assign headAdr   = r_adrMem[r_rdPtr];
    assign headLine  = r_lineMem[r_rdPtr];
    assign headWay   = r_wayMem[r_rdPtr];

`ifdef WBBUF_FORWARD_EN
    localparam int               c_OFFW     = $clog2(LINELEN / 8);
    localparam logic [PA_BITS-1:0] c_LINEMASK = ~((PA_BITS'(1) << c_OFFW) - PA_BITS'(1));

    logic [DEPTH-1:0] w_hitVec;

    // A slot is live when its distance from the read pointer is below the count.
    for (genvar i = 0; i < DEPTH; i++) begin : g_lookup
        logic [c_PTRW-1:0] w_slotOfs;
        assign w_slotOfs   = c_PTRW'(i) - r_rdPtr;
        assign w_hitVec[i] = (c_CNTW'(w_slotOfs) < r_count) &&
                             ((r_adrMem[i] & c_LINEMASK) == (LookupAdr & c_LINEMASK));
    end

    assign LookupHit = |w_hitVec;
`endif

endmodule : wbfifo
`default_nettype wire

// File: rtl/cache_writeback_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : cache_writeback_buffer
//  Brief    : Captures dirty evicted cache lines into a small FIFO and drains
//             each one to the bus as LINELEN/WORDLEN write beats.
//             Optional feature macro: WBBUF_FORWARD_EN (adds LookupAdr /
//             LookupHit to detect a line still pending write-back).
//  Revision : 1.0  initial release
// ============================================================================
module cache_writeback_buffer
    import cache_writeback_buffer_pkg::*;
#(
    parameter int NUMWAYS = c_DEF_NUMWAYS,
    parameter int LINELEN = c_DEF_LINELEN,
    parameter int WORDLEN = c_DEF_WORDLEN,
    parameter int PA_BITS = c_DEF_PA_BITS,
    parameter int DEPTH   = c_DEF_DEPTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       EvictReq,
    input  logic [NUMWAYS-1:0]         VictimWay,
    input  logic                       VictimDirty,
    input  logic [PA_BITS-1:0]         EvictAdr,
    input  logic [LINELEN-1:0]         EvictLine,
    output logic                       EvictReady,
    output logic                       BusValid,
    output logic [PA_BITS-1:0]         BusAdr,
    output logic [WORDLEN-1:0]         BusData,
    output logic                       BusLast,
    output logic [$clog2(NUMWAYS)-1:0] DrainWay,
    input  logic                       BusReady,
    output logic                       Busy
`ifdef WBBUF_FORWARD_EN
    ,
    input  logic [PA_BITS-1:0]         LookupAdr,
    output logic                       LookupHit
`endif
);

    localparam int c_BEATS    = LINELEN / WORDLEN;
    localparam int c_WAYBITS  = $clog2(NUMWAYS);
    localparam int c_BEATW    = (c_BEATS > 1) ? $clog2(c_BEATS) : 1;
    localparam int c_LINEIDXW = $clog2(LINELEN);
    localparam int c_BEATBYTES = WORDLEN / 8;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_lastEntry;
    logic                  w_lastBeat;
    logic [c_WAYBITS-1:0]  w_wayIdx;
    logic [PA_BITS-1:0]    w_headAdr;
    logic [LINELEN-1:0]    w_headLine;
    logic [c_WAYBITS-1:0]  w_headWay;
    logic [c_LINEIDXW-1:0] w_beatOfs;

    drainState_t           r_state;
    logic [c_BEATW-1:0]    r_beat;

    // Encode the one-hot victim way to a binary index.
    always_comb begin
        w_wayIdx = '0;
        for (int i = 0; i < NUMWAYS; i++) begin
            if (VictimWay[i]) begin
                w_wayIdx = c_WAYBITS'(i);
            end
        end
    end

    // Clean victims and empty way vectors are dropped; EvictReady is from the
    // registered count, so a same-cycle pop never opens a slot early.
    assign EvictReady = ~w_full;
    assign w_push     = EvictReq & EvictReady & VictimDirty & (|VictimWay);
    assign w_lastBeat = (r_beat == c_BEATW'(c_BEATS - 1));
    assign BusValid   = (r_state == SEND);
    assign BusLast    = BusValid & w_lastBeat;
    assign w_pop      = BusValid & BusReady & w_lastBeat;
    assign Busy       = ~w_empty;

    wbfifo #(
        .PA_BITS (PA_BITS),
        .LINELEN (LINELEN),
        .WAYBITS (c_WAYBITS),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .pushAdr   (EvictAdr),
        .pushLine  (EvictLine),
        .pushWay   (w_wayIdx),
        .pop       (w_pop),
        .full      (w_full),
        .empty     (w_empty),
        .lastEntry (w_lastEntry),
        .headAdr   (w_headAdr),
        .headLine  (w_headLine),
        .headWay   (w_headWay)
`ifdef WBBUF_FORWARD_EN
        ,
        .LookupAdr (LookupAdr),
        .LookupHit (LookupHit)
`endif
    );

    // Drain FSM: start on a non-empty FIFO, step beats on each handshake and
    // roll straight into the next entry when one is still queued.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_beat  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_beat <= '0;
                    if (!w_empty) begin
                        r_state <= SEND;
                    end
                end
                SEND: begin
                    if (BusReady) begin
                        if (w_lastBeat) begin
                            r_beat <= '0;
                            if (w_lastEntry && !w_push) begin
                                r_state <= IDLE;
                            end
                        end else begin
                            r_beat <= r_beat + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_beat  <= '0;
                end
            endcase
        end
    end

    assign w_beatOfs = c_LINEIDXW'(r_beat) * c_LINEIDXW'(WORDLEN);

    // Beat payload is driven only while sending; idle bus fields read zero.
    always_comb begin
        BusAdr   = '0;
        BusData  = '0;
        DrainWay = '0;
        if (BusValid) begin
            BusAdr   = w_headAdr + PA_BITS'(r_beat) * PA_BITS'(c_BEATBYTES);
            BusData  = w_headLine[w_beatOfs +: WORDLEN];
            DrainWay = w_headWay;
        end
    end

endmodule : cache_writeback_buffer
`default_nettype wire

// File: tb/tb_cache_writeback_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_cache_writeback_buffer
//  Brief    : Scoreboard bench for cache_writeback_buffer (default geometry).
//             Expected lines are queued when pushes are driven and checked
//             beat by beat as the bus drains them.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cache_writeback_buffer;
    import cache_writeback_buffer_pkg::*;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         EvictReq = 1'b0;
    logic [3:0]   VictimWay = '0;
    logic         VictimDirty = 1'b0;
    logic [31:0]  EvictAdr = '0;
    logic [511:0] EvictLine = '0;
    logic         EvictReady;
    logic         BusValid;
    logic [31:0]  BusAdr;
    logic [63:0]  BusData;
    logic         BusLast;
    logic [1:0]   DrainWay;
    logic         BusReady = 1'b0;
    logic         Busy;
`ifdef WBBUF_FORWARD_EN
    logic [31:0]  LookupAdr = '0;
    logic         LookupHit;
`endif

    cache_writeback_buffer dut (
        .clk         (clk),
        .reset       (reset),
        .EvictReq    (EvictReq),
        .VictimWay   (VictimWay),
        .VictimDirty (VictimDirty),
        .EvictAdr    (EvictAdr),
        .EvictLine   (EvictLine),
        .EvictReady  (EvictReady),
        .BusValid    (BusValid),
        .BusAdr      (BusAdr),
        .BusData     (BusData),
        .BusLast     (BusLast),
        .DrainWay    (DrainWay),
        .BusReady    (BusReady),
        .Busy        (Busy)
`ifdef WBBUF_FORWARD_EN
        ,
        .LookupAdr   (LookupAdr),
        .LookupHit   (LookupHit)
`endif
    );

    always #5 clk = ~clk;

    int       checks = 0;
    int       failures = 0;
    wbEntry_t sb[$];
    int       mBeat = 0;
    int       drained = 0;
    int       acceptedBeats = 0;
    bit       tbReset = 1'b1;

    function automatic logic [511:0] randLine();
        logic [511:0] l;
        for (int i = 0; i < 16; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    function automatic logic [1:0] wayIndex(input logic [3:0] oneHot);
        logic [1:0] idx = '0;
        for (int i = 0; i < 4; i++) if (oneHot[i]) idx = 2'(i);
        return idx;
    endfunction

    // Bus monitor: compares every beat against the head of the scoreboard.
    task automatic busMonitor();
        wbEntry_t     exp;
        logic [511:0] sh;
        logic [31:0]  expAdr;
        logic [63:0]  expData;
        forever begin
            @(negedge clk);
            if (tbReset) begin
                mBeat = 0;
            end else if (BusValid) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL bus_unexpected: BusValid=1 with BusAdr=%h, required no beat", BusAdr);
                end else begin
                    exp     = sb[0];
                    expAdr  = exp.adr + 32'(mBeat * 8);
                    sh      = exp.line >> (mBeat * 64);
                    expData = sh[63:0];
                    if (BusAdr !== expAdr) begin
                        failures++;
                        $display("FAIL bus_adr beat %0d: got %h, required %h", mBeat, BusAdr, expAdr);
                    end
                    checks++;
                    if (BusData !== expData) begin
                        failures++;
                        $display("FAIL bus_data beat %0d: got %h, required %h", mBeat, BusData, expData);
                    end
                    checks++;
                    if (BusLast !== (mBeat == BEATS - 1)) begin
                        failures++;
                        $display("FAIL bus_last beat %0d: got %b, required %b", mBeat, BusLast, (mBeat == BEATS - 1));
                    end
                    checks++;
                    if (DrainWay !== exp.way) begin
                        failures++;
                        $display("FAIL drain_way beat %0d: got %0d, required %0d", mBeat, DrainWay, exp.way);
                    end
                    if (BusReady) begin
                        acceptedBeats++;
                        if (mBeat == BEATS - 1) begin
                            void'(sb.pop_front());
                            drained++;
                            mBeat = 0;
                        end else begin
                            mBeat++;
                        end
                    end
                end
            end else begin
                checks++;
                if (BusAdr !== '0 || BusData !== '0 || DrainWay !== '0 || BusLast !== 1'b0) begin
                    failures++;
                    $display("FAIL idle_zero: adr=%h data=%h way=%0d last=%b, required all 0",
                             BusAdr, BusData, DrainWay, BusLast);
                end
            end
        end
    endtask

    // Drive one eviction for a cycle; queue it when the bench expects capture.
    task automatic drivePush(input logic [31:0] adr, input logic [3:0] way, input logic dirty,
                             input logic [511:0] line, input bit expectAccept);
        wbEntry_t e;
        EvictReq    = 1'b1;
        VictimWay   = way;
        VictimDirty = dirty;
        EvictAdr    = adr;
        EvictLine   = line;
        if (expectAccept) begin
            e.adr  = adr;
            e.line = line;
            e.way  = wayIndex(way);
            sb.push_back(e);
        end
        @(posedge clk); #1;
        EvictReq    = 1'b0;
        VictimDirty = 1'b0;
        VictimWay   = '0;
    endtask

    task automatic waitIdle(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(posedge clk); #1;
            if (!Busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        checks++;
        if (BusValid !== 1'b0 || BusLast !== 1'b0) begin
            failures++;
            $display("FAIL reset_bus: BusValid=%b BusLast=%b, required 0 0", BusValid, BusLast);
        end
        checks++;
        if (Busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy: got %b, required 0", Busy);
        end
        checks++;
        if (EvictReady !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready: got %b, required 1", EvictReady);
        end
        checks++;
        if (BusAdr !== '0 || BusData !== '0 || DrainWay !== '0) begin
            failures++;
            $display("FAIL reset_fields: adr=%h data=%h way=%0d, required 0", BusAdr, BusData, DrainWay);
        end
        reset   = 1'b0;
        tbReset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_single_drain();
        int d0 = drained;
        int b0 = acceptedBeats;
        bit ok;
        BusReady = 1'b1;
        drivePush(32'h8000_1000, 4'b0100, 1'b1, randLine(), 1'b1);
        waitIdle(60, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL single_timeout: Busy=%b, required 0 within 60 cycles", Busy);
        end
        checks++;
        if (acceptedBeats - b0 != 8 || drained - d0 != 1) begin
            failures++;
            $display("FAIL single_beats: beats=%0d lines=%0d, required 8 1", acceptedBeats - b0, drained - d0);
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL single_pending: %0d lines undrained, required 0", sb.size());
        end
    endtask

    task automatic test_clean_victim();
        bit sawValid = 1'b0;
        bit sawBusy  = 1'b0;
        BusReady = 1'b1;
        drivePush(32'h8000_5000, 4'b0010, 1'b0, randLine(), 1'b0);
        drivePush(32'h8000_6000, 4'b0000, 1'b1, randLine(), 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (BusValid) sawValid = 1'b1;
            if (Busy) sawBusy = 1'b1;
        end
        checks++;
        if (sawValid || sawBusy) begin
            failures++;
            $display("FAIL clean_drop: sawValid=%b sawBusy=%b, required 0 0", sawValid, sawBusy);
        end
        checks++;
        if (EvictReady !== 1'b1) begin
            failures++;
            $display("FAIL clean_ready: got %b, required 1", EvictReady);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_full();
        int d0 = drained;
        int n = 0;
        BusReady = 1'b0;
        drivePush(32'h8000_2000, 4'b0001, 1'b1, randLine(), 1'b1);
        drivePush(32'h8000_3040, 4'b1000, 1'b1, randLine(), 1'b1);
        checks++;
        if (EvictReady !== 1'b0 || Busy !== 1'b1) begin
            failures++;
            $display("FAIL full_flags: EvictReady=%b Busy=%b, required 0 1", EvictReady, Busy);
        end
        drivePush(32'h8000_4000, 4'b0010, 1'b1, randLine(), 1'b0);
        checks++;
        if (EvictReady !== 1'b0) begin
            failures++;
            $display("FAIL full_third: EvictReady=%b, required 0", EvictReady);
        end
        BusReady = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (BusValid) n++;
            else if (n > 0) break;
        end
        checks++;
        if (n != 16) begin
            failures++;
            $display("FAIL full_gapless: %0d consecutive beats, required 16", n);
        end
        @(posedge clk); #1;
        checks++;
        if (Busy !== 1'b0 || sb.size() != 0 || drained - d0 != 2) begin
            failures++;
            $display("FAIL full_drain: Busy=%b pending=%0d lines=%0d, required 0 0 2",
                     Busy, sb.size(), drained - d0);
        end
    endtask

    task automatic test_back_to_back();
        wbEntry_t e;
        bit found = 1'b0;
        bit ok;
        int n = 0;
        BusReady = 1'b1;
        drivePush(32'h8000_7000, 4'b0001, 1'b1, randLine(), 1'b1);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (BusLast) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found || EvictReady !== 1'b1) begin
            failures++;
            $display("FAIL b2b_last: found=%b EvictReady=%b, required 1 1", found, EvictReady);
        end
        EvictReq    = 1'b1;
        VictimWay   = 4'b1000;
        VictimDirty = 1'b1;
        EvictAdr    = 32'h8000_8000;
        EvictLine   = randLine();
        e.adr  = EvictAdr;
        e.line = EvictLine;
        e.way  = 2'd3;
        sb.push_back(e);
        @(posedge clk); #1;
        EvictReq    = 1'b0;
        VictimDirty = 1'b0;
        VictimWay   = '0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (BusValid) n++;
            else break;
        end
        checks++;
        if (n != 8) begin
            failures++;
            $display("FAIL b2b_follow: %0d beats after overlap, required 8", n);
        end
        waitIdle(10, ok);
        checks++;
        if (!ok || sb.size() != 0) begin
            failures++;
            $display("FAIL b2b_drain: idle=%b pending=%0d, required 1 0", ok, sb.size());
        end
    endtask

    task automatic test_stall();
        int          beats = 0;
        bit          held = 1'b0;
        logic [31:0] hAdr;
        logic [63:0] hData;
        logic        hLast;
        BusReady = 1'b0;
        drivePush(32'h8000_9000, 4'b0100, 1'b1, randLine(), 1'b1);
        for (int i = 0; i < 80; i++) begin
            @(posedge clk); #1;
            BusReady = ~BusReady;
            @(negedge clk);
            if (held) begin
                checks++;
                if (BusAdr !== hAdr || BusData !== hData || BusLast !== hLast) begin
                    failures++;
                    $display("FAIL stall_hold: adr=%h last=%b, required adr=%h last=%b", BusAdr, BusLast, hAdr, hLast);
                end
            end
            held  = BusValid && !BusReady;
            hAdr  = BusAdr;
            hData = BusData;
            hLast = BusLast;
            if (BusValid && BusReady) beats++;
            if (!Busy) break;
        end
        checks++;
        if (beats != 8 || Busy !== 1'b0) begin
            failures++;
            $display("FAIL stall_count: beats=%0d Busy=%b, required 8 0", beats, Busy);
        end
        @(posedge clk); #1;
        BusReady = 1'b1;
    endtask

    task automatic test_reset_midburst();
        int seen = 0;
        bit reached = 1'b0;
        bit sawValid = 1'b0;
        BusReady = 1'b1;
        drivePush(32'h8000_A000, 4'b0010, 1'b1, randLine(), 1'b1);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (BusValid) begin
                if (seen == 3) begin
                    reached = 1'b1;
                    break;
                end
                seen++;
            end
        end
        tbReset = 1'b1;
        reset   = 1'b1;
        #1;
        checks++;
        if (!reached || BusValid !== 1'b0 || EvictReady !== 1'b1 || Busy !== 1'b0) begin
            failures++;
            $display("FAIL midreset: reached=%b BusValid=%b EvictReady=%b Busy=%b, required 1 0 1 0",
                     reached, BusValid, EvictReady, Busy);
        end
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        reset   = 1'b0;
        tbReset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (BusValid) sawValid = 1'b1;
        end
        checks++;
        if (sawValid) begin
            failures++;
            $display("FAIL midreset_quiet: BusValid seen after reset, required none");
        end
        @(posedge clk); #1;
    endtask

`ifdef WBBUF_FORWARD_EN
    task automatic test_forward();
        bit ok;
        BusReady  = 1'b0;
        LookupAdr = 32'h8000_1020;
        drivePush(32'h8000_1000, 4'b0001, 1'b1, randLine(), 1'b1);
        checks++;
        if (LookupHit !== 1'b1) begin
            failures++;
            $display("FAIL fwd_hit: got %b, required 1", LookupHit);
        end
        LookupAdr = 32'h8000_1040;
        #1;
        checks++;
        if (LookupHit !== 1'b0) begin
            failures++;
            $display("FAIL fwd_miss: got %b, required 0", LookupHit);
        end
        LookupAdr = 32'h8000_1020;
        BusReady  = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (LookupHit !== 1'b1 || BusValid !== 1'b1) begin
            failures++;
            $display("FAIL fwd_midburst: hit=%b valid=%b, required 1 1", LookupHit, BusValid);
        end
        waitIdle(30, ok);
        checks++;
        if (!ok || LookupHit !== 1'b0) begin
            failures++;
            $display("FAIL fwd_after_pop: idle=%b hit=%b, required 1 0", ok, LookupHit);
        end
    endtask
`endif

    initial begin
        fork
            busMonitor();
        join_none
        test_reset();
        test_single_drain();
        test_clean_victim();
        test_full();
        test_back_to_back();
        test_stall();
        test_reset_midburst();
`ifdef WBBUF_FORWARD_EN
        test_forward();
`endif
        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_cache_writeback_buffer
`default_nettype wire
